// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback select, 32x32 register file with write-through bypass, write counter
//
// Purpose:
//   Picks the writeback value (ALU result or memory read data) and commits it
//   to the architectural register file. Serves two combinational decode read
//   ports that bypass a same-cycle write. Exports the writeback result,
//   destination and effective enable to the forwarding unit. Keeps a wrapping
//   count of cycles with the write enable asserted.
//
// Ports:
//   clk           pipeline clock, rising-edge state updates
//   rst           asynchronous active-low reset
//   Alu_out_WB    ALU result from MEM/WB
//   DM_RD_out_WB  data-memory read data from MEM/WB
//   ResultSrc_WB  0 = ALU result, 1 = memory read data
//   RF_WE_WB      register-file write enable
//   RD_WB         destination register index
//   A1, A2        decode read addresses
//   RD1, RD2      decode read data (combinational)
//   Result_W      selected writeback value (combinational)
//   RD_W          destination index to forwarding unit
//   RF_WE_W       effective write enable (x0 writes suppressed)
//   wr_count      cycles with RF_WE_WB = 1 since reset, wrapping

module writeback_regfile #(
  parameter  int DATA_W = 32,
  parameter  int NREG   = 32,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Alu_out_WB,
  input  logic [DATA_W-1:0] DM_RD_out_WB,
  input  logic              ResultSrc_WB,
  input  logic              RF_WE_WB,
  input  logic [AW-1:0]     RD_WB,
  input  logic [AW-1:0]     A1,
  input  logic [AW-1:0]     A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] Result_W,
  output logic [AW-1:0]     RD_W,
  output logic              RF_WE_W,
  output logic [31:0]       wr_count
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [31:0]       wr_count_q;
  logic [31:0]       wr_count_d;

  // Forwarding outputs are pure functions of the MEM/WB inputs.
  always_comb begin
    Result_W = ResultSrc_WB ? DM_RD_out_WB : Alu_out_WB;
    RD_W     = RD_WB;
    RF_WE_W  = RF_WE_WB && (RD_WB != '0);
  end

  // RF_WE_W already excludes x0, so entry 0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (RF_WE_W) begin
      regs_d[RD_WB] = Result_W;
    end
  end

  // The counter counts every enabled cycle, including writes aimed at x0.
  always_comb begin
    wr_count_d = wr_count_q + {31'd0, RF_WE_WB};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Read ports: x0 reads zero, then same-cycle bypass, then stored value.
  always_comb begin
    if (A1 == '0) begin
      RD1 = '0;
    end else if (RF_WE_W && (A1 == RD_WB)) begin
      RD1 = Result_W;
    end else begin
      RD1 = regs_q[A1];
    end

    if (A2 == '0) begin
      RD2 = '0;
    end else if (RF_WE_W && (A2 == RD_WB)) begin
      RD2 = Result_W;
    end else begin
      RD2 = regs_q[A2];
    end
  end

  assign wr_count = wr_count_q;

endmodule
